braille_trial_ctrl: RTL and testbench

//  Sequences one timed Braille recognition trial around the 1 s LFSR timer (l_f_s_r_count1s).

---
 rtl/braille_trial_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_braille_trial_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/braille_trial_ctrl.sv
// Sequences one timed Braille recognition trial: arms the 1 s timer, counts the answer
// window, grades submitted answers with limited retries, tallies score and holds the result.
module braille_trial_ctrl #(
  parameter int unsigned TRIAL_SECS  = 10,
  parameter int unsigned RESULT_SECS = 2,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [5:0]         target_i,
  input  logic               submit_i,
  input  logic [5:0]         answer_i,
  input  logic               timeout_1s_i,
  output logic               timer_rst_o,
  output logic               busy_o,
  output logic [3:0]         secs_left_o,
  output logic [1:0]         tries_left_o,
  output logic               correct_o,
  output logic               wrong_o,
  output logic               timed_out_o,
  output logic [SCORE_W-1:0] score_o
);

  localparam int unsigned DOTS_W  = 6;
  localparam int unsigned SECS_W  = 4;
  localparam int unsigned TRIES_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_CHECK,
    S_RESULT
  } state_e;

  state_e               state_q, state_d;
  logic                 timer_rst_q, timer_rst_d;
  logic                 busy_q, busy_d;
  logic [SECS_W-1:0]    secs_left_q, secs_left_d;
  logic [TRIES_W-1:0]   tries_left_q, tries_left_d;
  logic                 correct_q, correct_d;
  logic                 wrong_q, wrong_d;
  logic                 timed_out_q, timed_out_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 pending_q, pending_d;
  logic [DOTS_W-1:0]    target_q, target_d;
  logic [DOTS_W-1:0]    answer_q, answer_d;
  logic [SECS_W-1:0]    hold_q, hold_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_rst_q  <= 1'b0;
      busy_q       <= 1'b0;
      secs_left_q  <= '0;
      tries_left_q <= TRIES_W'(MAX_TRIES);
      correct_q    <= 1'b0;
      wrong_q      <= 1'b0;
      timed_out_q  <= 1'b0;
      score_q      <= '0;
      pending_q    <= 1'b0;
      target_q     <= '0;
      answer_q     <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      timer_rst_q  <= timer_rst_d;
      busy_q       <= busy_d;
      secs_left_q  <= secs_left_d;
      tries_left_q <= tries_left_d;
      correct_q    <= correct_d;
      wrong_q      <= wrong_d;
      timed_out_q  <= timed_out_d;
      score_q      <= score_d;
      pending_q    <= pending_d;
      target_q     <= target_d;
      answer_q     <= answer_d;
      hold_q       <= hold_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    timer_rst_d  = timer_rst_q;
    busy_d       = busy_q;
    secs_left_d  = secs_left_q;
    tries_left_d = tries_left_q;
    correct_d    = correct_q;
    wrong_d      = wrong_q;
    timed_out_d  = timed_out_q;
    score_d      = score_q;
    pending_d    = pending_q;
    target_d     = target_q;
    answer_d     = answer_q;
    hold_d       = hold_q;

    unique case (state_q)
      S_IDLE: begin
        timer_rst_d = 1'b0;
        if (start_i) begin
          state_d      = S_ARM;
          target_d     = target_i;
          secs_left_d  = SECS_W'(TRIAL_SECS);
          tries_left_d = TRIES_W'(MAX_TRIES);
          correct_d    = 1'b0;
          wrong_d      = 1'b0;
          timed_out_d  = 1'b0;
          busy_d       = 1'b1;
          pending_d    = 1'b0;
        end
      end

      S_ARM: begin
        timer_rst_d = 1'b1;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        timer_rst_d = 1'b1;
        if (submit_i) begin
          answer_d  = answer_i;
          state_d   = S_CHECK;
          pending_d = pending_q | timeout_1s_i;
        end else if (timeout_1s_i || pending_q) begin
          // A pending tick is consumed first; a coincident live tick stays pending.
          pending_d = pending_q & timeout_1s_i;
          if (secs_left_q == SECS_W'(1)) begin
            secs_left_d = '0;
            timed_out_d = 1'b1;
            state_d     = S_RESULT;
            timer_rst_d = 1'b0;
            hold_d      = SECS_W'(RESULT_SECS);
            pending_d   = 1'b0;
          end else begin
            secs_left_d = secs_left_q - SECS_W'(1);
          end
        end
      end

      S_CHECK: begin
        timer_rst_d = 1'b1;
        pending_d   = pending_q | timeout_1s_i;
        if (answer_q == target_q) begin
          correct_d   = 1'b1;
          if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          state_d     = S_RESULT;
          timer_rst_d = 1'b0;
          hold_d      = SECS_W'(RESULT_SECS);
          pending_d   = 1'b0;
        end else begin
          tries_left_d = tries_left_q - TRIES_W'(1);
          if (tries_left_q == TRIES_W'(1)) begin
            wrong_d     = 1'b1;
            state_d     = S_RESULT;
            timer_rst_d = 1'b0;
            hold_d      = SECS_W'(RESULT_SECS);
            pending_d   = 1'b0;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_RESULT: begin
        timer_rst_d = 1'b1;
        if (timeout_1s_i) begin
          if (hold_q <= SECS_W'(1)) begin
            hold_d      = '0;
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            correct_d   = 1'b0;
            wrong_d     = 1'b0;
            timed_out_d = 1'b0;
            secs_left_d = '0;
            timer_rst_d = 1'b0;
          end else begin
            hold_d = hold_q - SECS_W'(1);
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        timer_rst_d = 1'b0;
      end
    endcase
  end

  assign timer_rst_o  = timer_rst_q;
  assign busy_o       = busy_q;
  assign secs_left_o  = secs_left_q;
  assign tries_left_o = tries_left_q;
  assign correct_o    = correct_q;
  assign wrong_o      = wrong_q;
  assign timed_out_o  = timed_out_q;
  assign score_o      = score_q;

endmodule

// File: tb/tb_braille_trial_ctrl.sv
// Directed bench for braille_trial_ctrl: stimulus queues the expected output snapshot for
// every output change; a negedge monitor pops and compares each time the outputs move.
module tb_braille_trial_ctrl;

  localparam int unsigned SW = 2;
  localparam int unsigned VW = 11 + SW;
  typedef logic [VW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    target = '0;
  logic          submit = 1'b0;
  logic [5:0]    answer = '0;
  logic          tick = 1'b0;
  logic          timer_rst, busy, correct, wrong, timed_out;
  logic [3:0]    secs_left;
  logic [1:0]    tries_left;
  logic [SW-1:0] score;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t exp_q[$];

  braille_trial_ctrl #(
    .TRIAL_SECS (10),
    .RESULT_SECS(2),
    .MAX_TRIES  (3),
    .SCORE_W    (SW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .target_i    (target),
    .submit_i    (submit),
    .answer_i    (answer),
    .timeout_1s_i(tick),
    .timer_rst_o (timer_rst),
    .busy_o      (busy),
    .secs_left_o (secs_left),
    .tries_left_o(tries_left),
    .correct_o   (correct),
    .wrong_o     (wrong),
    .timed_out_o (timed_out),
    .score_o     (score)
  );

  always #5 clk = ~clk;

  // Expected snapshot: {timer_rst, busy, secs_left, tries_left, {correct,wrong,timed_out}, score}
  task automatic ex(input logic tr, input logic b, input logic [3:0] s, input logic [1:0] t,
                    input logic [2:0] f, input logic [SW-1:0] sc);
    exp_q.push_back({tr, b, s, t, f, sc});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [5:0] t);
    start = 1'b1; target = t; cyc(1); start = 1'b0;
  endtask

  task automatic do_submit(input logic [5:0] a);
    submit = 1'b1; answer = a; cyc(1); submit = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(1); tick = 1'b0;
  endtask

  // Start a trial, answer correctly at once, then let the result hold expire
  task automatic trial_ok(input logic [5:0] t, input logic [SW-1:0] s_old, input logic [SW-1:0] s_new);
    ex(0, 1, 10, 3, 3'b000, s_old);
    do_start(t);
    ex(1, 1, 10, 3, 3'b000, s_old);
    cyc(2);
    ex(0, 1, 10, 3, 3'b100, s_new);
    ex(1, 1, 10, 3, 3'b100, s_new);
    do_submit(t);
    cyc(3);
    ex(0, 0, 0, 3, 3'b000, s_new);
    do_tick(); cyc(1); do_tick(); cyc(2);
  endtask

  // Monitor: every change on the outputs must match the next queued snapshot
  initial begin
    vec_t prev, cur, want;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {timer_rst, busy, secs_left, tries_left, correct, wrong, timed_out, score};
      if (cur !== prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change t=%0t got %b (tr,busy,secs,tries,cwt,score) want no change", $time, cur);
        end else begin
          want = exp_q.pop_front();
          if (cur !== want) begin
            miscompares++;
            $display("FAIL out_vec t=%0t got %b want %b (tr,busy,secs,tries,cwt,score)", $time, cur, want);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got timeout want end of stimulus");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    ex(0, 0, 0, 3, 3'b000, 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Stray submit and tick in IDLE change nothing
    do_submit(6'h2A); cyc(1); do_tick(); cyc(2);

    // Correct answer after two ticks, then result hold of two ticks
    ex(0, 1, 10, 3, 3'b000, 0);
    do_start(6'h2A);
    ex(1, 1, 10, 3, 3'b000, 0);
    cyc(2);
    ex(1, 1, 9, 3, 3'b000, 0); do_tick(); cyc(1);
    ex(1, 1, 8, 3, 3'b000, 0); do_tick(); cyc(1);
    ex(0, 1, 8, 3, 3'b100, 1);
    ex(1, 1, 8, 3, 3'b100, 1);
    do_submit(6'h2A);
    cyc(3);
    ex(0, 0, 0, 3, 3'b000, 1);
    do_tick(); cyc(1); do_tick(); cyc(2);

    // Three wrong answers exhaust the tries
    ex(0, 1, 10, 3, 3'b000, 1);
    do_start(6'h2A);
    ex(1, 1, 10, 3, 3'b000, 1);
    cyc(2);
    ex(1, 1, 10, 2, 3'b000, 1); do_submit(6'h01); cyc(2);
    ex(1, 1, 10, 1, 3'b000, 1); do_submit(6'h02); cyc(2);
    ex(0, 1, 10, 0, 3'b010, 1);
    ex(1, 1, 10, 0, 3'b010, 1);
    do_submit(6'h03); cyc(3);
    ex(0, 0, 0, 0, 3'b000, 1);
    do_tick(); cyc(1); do_tick(); cyc(2);

    // Window expires after ten ticks
    ex(0, 1, 10, 3, 3'b000, 1);
    do_start(6'h2A);
    ex(1, 1, 10, 3, 3'b000, 1);
    cyc(2);
    for (int i = 9; i >= 1; i--) begin
      ex(1, 1, 4'(i), 3, 3'b000, 1);
      do_tick(); cyc(1);
    end
    ex(0, 1, 0, 3, 3'b001, 1);
    ex(1, 1, 0, 3, 3'b001, 1);
    do_tick(); cyc(2);
    ex(0, 0, 0, 3, 3'b000, 1);
    do_tick(); cyc(1); do_tick(); cyc(2);

    // Submit coincident with a tick at secs_left=5: pending tick lands after CHECK
    ex(0, 1, 10, 3, 3'b000, 1);
    do_start(6'h2A);
    ex(1, 1, 10, 3, 3'b000, 1);
    cyc(2);
    for (int i = 9; i >= 5; i--) begin
      ex(1, 1, 4'(i), 3, 3'b000, 1);
      do_tick(); cyc(1);
    end
    ex(1, 1, 5, 2, 3'b000, 1);
    ex(1, 1, 4, 2, 3'b000, 1);
    submit = 1'b1; answer = 6'h01; tick = 1'b1;
    cyc(1);
    submit = 1'b0; tick = 1'b0;
    cyc(3);

    // Start in WAIT ignored: original target 2A still graded correct
    do_start(6'h15); cyc(1);
    ex(0, 1, 4, 2, 3'b100, 2);
    ex(1, 1, 4, 2, 3'b100, 2);
    do_submit(6'h2A); cyc(3);
    do_start(6'h15); cyc(1);
    ex(0, 0, 0, 2, 3'b000, 2);
    do_tick(); cyc(1); do_tick(); cyc(2);

    // Reset mid-WAIT returns everything to reset values, including score
    ex(0, 1, 10, 3, 3'b000, 2);
    do_start(6'h2A);
    ex(1, 1, 10, 3, 3'b000, 2);
    cyc(2);
    ex(1, 1, 9, 3, 3'b000, 2); do_tick(); cyc(1);
    ex(0, 0, 0, 3, 3'b000, 0);
    #2 rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Score saturates at 3 with a 2-bit counter; zero target is legal; tick in ARM ignored
    ex(0, 1, 10, 3, 3'b000, 0);
    do_start(6'h00);
    ex(1, 1, 10, 3, 3'b000, 0);
    do_tick(); cyc(1);
    ex(0, 1, 10, 3, 3'b100, 1);
    ex(1, 1, 10, 3, 3'b100, 1);
    do_submit(6'h00); cyc(3);
    ex(0, 0, 0, 3, 3'b000, 1);
    do_tick(); cyc(1); do_tick(); cyc(2);
    trial_ok(6'h00, 1, 2);
    trial_ok(6'h3F, 2, 3);
    trial_ok(6'h00, 3, 3);

    cyc(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d snapshots never observed want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
